// File: rtl/pack_str_serializer.sv
// Frame-to-stream serializer: accepts a masked frame of pack_str_t elements and emits
// enabled elements one per beat. Optional out_par port enabled by PACK_STR_SER_PARITY_EN.
package pack_str_pkg;
  typedef struct packed {
    logic a;
    logic b;
  } pack_str_t;
endpackage

module pack_str_serializer
  import pack_str_pkg::*;
#(
  parameter int NUM_ELEM = 3,
  parameter int CNT_W    = 8,
  localparam int IDX_W   = $clog2(NUM_ELEM)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                frm_valid,
  output logic                frm_ready,
  input  pack_str_t           frm_data [NUM_ELEM],
  input  logic [NUM_ELEM-1:0] frm_mask,
  output logic                out_valid,
  input  logic                out_ready,
  output pack_str_t           out_data,
  output logic [IDX_W-1:0]    out_idx,
  output logic                out_last,
  output logic                drop_pulse,
  output logic [CNT_W-1:0]    frm_cnt
`ifdef PACK_STR_SER_PARITY_EN
  ,
  output logic                out_par
`endif
);

  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  state_t              state, state_nxt;
  pack_str_t           elem_buf [NUM_ELEM];
  logic [NUM_ELEM-1:0] rem;
  logic [IDX_W-1:0]    cur;
  logic                accept, accept_load, accept_drop, beat_hs;

  // Lowest set bit of the remaining mask selects the current element.
  always_comb begin
    cur = '0;
    for (int i = NUM_ELEM - 1; i >= 0; i--) begin
      cur = rem[i] ? IDX_W'(i) : cur;
    end
  end

  assign out_valid   = (state == SEND);
  assign out_idx     = cur;
  assign out_data    = elem_buf[cur];
  assign out_last    = (rem != '0) && ((rem & (rem - NUM_ELEM'(1))) == '0);
  assign beat_hs     = out_valid && out_ready;
  assign accept      = frm_valid && frm_ready;
  assign accept_load = accept && (frm_mask != '0);
  assign accept_drop = accept && (frm_mask == '0);

  // Frame-ready and next-state logic; a new frame may chain onto the final beat.
  always_comb begin
    state_nxt = state;
    frm_ready = 1'b0;
    case (state)
      IDLE: begin
        frm_ready = !rst;
        state_nxt = accept_load ? SEND : IDLE;
      end
      SEND: begin
        frm_ready = !rst && out_last && out_ready;
        if (beat_hs && out_last) begin
          state_nxt = accept_load ? SEND : IDLE;
        end else begin
          state_nxt = SEND;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Frame buffer and remaining mask change only on accept or handshake, holding outputs under backpressure.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem <= '0;
      for (int i = 0; i < NUM_ELEM; i++) begin
        elem_buf[i] <= '0;
      end
    end else if (accept_load) begin
      rem <= frm_mask;
      for (int i = 0; i < NUM_ELEM; i++) begin
        elem_buf[i] <= frm_data[i];
      end
    end else if (beat_hs) begin
      rem[cur] <= 1'b0;
    end
  end

  // Completed-frame counter and zero-mask drop pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frm_cnt    <= '0;
      drop_pulse <= 1'b0;
    end else begin
      drop_pulse <= accept_drop;
      if (beat_hs && out_last) begin
        frm_cnt <= frm_cnt + CNT_W'(1);
      end
    end
  end

`ifdef PACK_STR_SER_PARITY_EN
  function automatic logic even_par(input pack_str_t d, input logic [IDX_W-1:0] idx);
    return ^{d.a, d.b, idx};
  endfunction

  assign out_par = even_par(out_data, out_idx);
`endif

endmodule

// File: tb/tb_pack_str_serializer.sv
// Directed, table-driven bench for pack_str_serializer (default build, NUM_ELEM=3, CNT_W=8).
module tb_pack_str_serializer;
  import pack_str_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            frm_valid;
  logic            frm_ready;
  pack_str_t       frm_data [3];
  logic [2:0]      frm_mask;
  logic            out_valid;
  logic            out_ready;
  pack_str_t       out_data;
  logic [1:0]      out_idx;
  logic            out_last;
  logic            drop_pulse;
  logic [7:0]      frm_cnt;

  int tests = 0;
  int fails = 0;
  logic [7:0] exp_cnt;

  typedef struct {
    logic [2:0] mask;
    logic [5:0] data;     // element i at [2i+1:2i] as {a,b}
    int         nbeats;
    logic [5:0] exp_idx;  // beat k index at [2k+1:2k]
    logic [5:0] exp_dat;  // beat k data at [2k+1:2k]
  } vec_t;

  vec_t vecs [5];

  pack_str_serializer #(.NUM_ELEM(3), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .frm_valid(frm_valid), .frm_ready(frm_ready),
    .frm_data(frm_data), .frm_mask(frm_mask),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_idx(out_idx), .out_last(out_last),
    .drop_pulse(drop_pulse), .frm_cnt(frm_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_frame(input logic [2:0] mask, input logic [5:0] data);
    frm_mask = mask;
    for (int i = 0; i < 3; i++) frm_data[i] = data[2*i +: 2];
  endtask

  task automatic run_vec(input vec_t v);
    @(negedge clk);
    set_frame(v.mask, v.data);
    frm_valid = 1'b1;
    chk("ready_idle", frm_ready, 1);
    @(posedge clk); #1;
    frm_valid = 1'b0;
    set_frame(3'b111, 6'b111111);  // must not affect frame in flight
    if (v.nbeats == 0) begin
      chk("drop_pulse", drop_pulse, 1);
      chk("drop_no_beat", out_valid, 0);
      @(posedge clk); #1;
      chk("drop_one_cycle", drop_pulse, 0);
      chk("drop_no_beat2", out_valid, 0);
    end else begin
      for (int k = 0; k < v.nbeats; k++) begin
        chk("beat_valid", out_valid, 1);
        chk("beat_idx", out_idx, v.exp_idx[2*k +: 2]);
        chk("beat_data", out_data, v.exp_dat[2*k +: 2]);
        chk("beat_last", out_last, (k == v.nbeats - 1) ? 1 : 0);
        @(posedge clk); #1;
      end
      exp_cnt = exp_cnt + 8'd1;
      chk("frame_end_idle", out_valid, 0);
    end
    chk("frm_cnt", frm_cnt, exp_cnt);
  endtask

  task automatic burst(input int n);
    @(negedge clk);
    set_frame(3'b001, 6'b000001);
    frm_valid = 1'b1;
    repeat (n) @(posedge clk);
    #1 frm_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0] = '{3'b111, 6'b11_10_01, 3, 6'b10_01_00, 6'b11_10_01};
    vecs[1] = '{3'b101, 6'b01_11_10, 2, 6'b00_10_00, 6'b00_01_10};
    vecs[2] = '{3'b010, 6'b10_01_11, 1, 6'b00_00_01, 6'b00_00_01};
    vecs[3] = '{3'b110, 6'b10_11_00, 2, 6'b00_10_01, 6'b00_10_11};
    vecs[4] = '{3'b000, 6'b01_10_11, 0, 6'b00_00_00, 6'b00_00_00};

    rst = 1'b1; frm_valid = 1'b0; out_ready = 1'b1; exp_cnt = 8'd0;
    set_frame(3'b000, 6'b000000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", frm_ready, 0);
    chk("rst_cnt", frm_cnt, 0);
    chk("rst_data", out_data, 0);
    chk("rst_idx", out_idx, 0);
    @(negedge clk) rst = 1'b0;

    for (int t = 0; t < 5; t++) run_vec(vecs[t]);

    // Backpressure on idx 1.
    @(negedge clk);
    set_frame(3'b111, 6'b11_10_01);
    frm_valid = 1'b1;
    @(posedge clk); #1;
    frm_valid = 1'b0;
    chk("bp_idx0", out_idx, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("bp_valid", out_valid, 1);
      chk("bp_idx", out_idx, 1);
      chk("bp_data", out_data, 2'b10);
      chk("bp_ready", frm_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    chk("bp_idx_held", out_idx, 1);
    @(posedge clk); #1;
    chk("bp_idx2", out_idx, 2);
    chk("bp_last", out_last, 1);
    @(posedge clk); #1;
    exp_cnt = exp_cnt + 8'd1;
    chk("bp_done", out_valid, 0);
    chk("bp_cnt", frm_cnt, exp_cnt);

    // Back-to-back frames: second offered during last beat of the first.
    @(negedge clk);
    set_frame(3'b111, 6'b11_10_01);
    frm_valid = 1'b1;
    @(posedge clk); #1;
    frm_valid = 1'b0;
    for (int k = 0; k < 6; k++) begin
      chk("b2b_valid", out_valid, 1);
      chk("b2b_idx", out_idx, k % 3);
      chk("b2b_data", out_data, (k < 3) ? (k + 1) : (3 - (k - 3)));
      if (k == 2) begin
        set_frame(3'b111, 6'b01_10_11);
        frm_valid = 1'b1;
        chk("b2b_ready", frm_ready, 1);
      end else begin
        frm_valid = 1'b0;
      end
      @(posedge clk); #1;
    end
    frm_valid = 1'b0;
    exp_cnt = exp_cnt + 8'd2;
    chk("b2b_done", out_valid, 0);
    chk("b2b_cnt", frm_cnt, exp_cnt);

    // Reset mid-SEND after one beat.
    @(negedge clk);
    set_frame(3'b111, 6'b11_10_01);
    frm_valid = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", frm_ready, 0);
    frm_valid = 1'b0;
    @(negedge clk) rst = 1'b0;
    exp_cnt = 8'd0;
    #1;
    chk("post_rst_cnt", frm_cnt, 0);
    chk("post_rst_ready", frm_ready, 1);
    repeat (3) @(posedge clk);
    #1;
    chk("post_rst_no_beat", out_valid, 0);

    // Counter wrap 255 -> 0.
    burst(255);
    chk("cnt_255", frm_cnt, 8'd255);
    burst(1);
    chk("cnt_wrap", frm_cnt, 8'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/pack_str_serializer.md
Name: pack_str_serializer

Overview:
- Transmit-side block: accepts a whole frame of pack_str_t elements (unpacked array plus packed enable mask) via valid/ready and emits one element per beat on a serial valid/ready stream, tagged with index and last flag.
- Sits upstream of consumers that take per-element pack_str_t traffic; converts array-shaped ports into a streamed sequence.

Parameters:
- NUM_ELEM, 3, number of elements per frame; legal range 2..16.
- CNT_W, 8, width of the sent-frame counter.
- IDX_W (localparam), $clog2(NUM_ELEM), element index width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- frm_valid  input  1  frame offered.
- frm_ready  output  1  frame accepted when frm_valid && frm_ready.
- frm_data  input  pack_str_t [NUM_ELEM] unpacked  frame elements, index 0..NUM_ELEM-1.
- frm_mask  input  NUM_ELEM packed  bit i = 1 means element i is sent.
- out_valid  output  1  beat valid.
- out_ready  input  1  downstream ready.
- out_data  output  pack_str_t (2)  current element {a,b}.
- out_idx  output  IDX_W  array index of the current element.
- out_last  output  1  current beat is the final enabled element of the frame.
- drop_pulse  output  1  one-cycle pulse when a frame with an all-zero mask is accepted.
- frm_cnt  output  CNT_W  count of completed frames; wraps from 2^CNT_W-1 to 0.

Behaviour:
- Reset (async assert, sync release) sets:
  - state IDLE, out_valid 0, out_idx 0, out_data 0, out_last 0, drop_pulse 0, frm_cnt 0, internal buffer and remaining mask 0.
  - frm_ready is forced 0 while rst is high.
- FSM has two states: IDLE and SEND.
- IDLE:
  - frm_ready = 1.
  - On accept with frm_mask != 0: latch frm_data into buf and frm_mask into rem; next state SEND.
  - On accept with frm_mask == 0: stay IDLE; drop_pulse = 1 for the following cycle; no beats; frm_cnt unchanged.
- SEND:
  - out_valid = 1.
  - cur = index of the lowest set bit of rem; out_idx = cur; out_data = buf[cur].
  - out_last = 1 iff rem has exactly one bit set.
  - On out_valid && out_ready: clear rem[cur].
  - If out_last, the same handshake increments frm_cnt and ends the frame.
- Frame end:
  - With no new frame accepted: next state IDLE.
  - frm_ready in SEND = out_last && out_ready (combinational pass-through).
  - A frame accepted on the final handshake loads buf/rem and stays in SEND. Zero bubble: its first beat is presented next cycle.
  - A zero-mask frame accepted at frame end goes to IDLE and pulses drop_pulse.
- Latency: frame accepted at edge N drives out_valid high in the cycle after edge N. Steady throughput is 1 beat/cycle.
- Stability: out_data, out_idx and out_last are held while out_valid && !out_ready, because rem and buf change only on a handshake.
- Elements with mask bit 0 are skipped. Beats are emitted in ascending index order.
- frm_data and frm_mask are sampled only on accept; later changes while SEND do not affect the frame in flight.
- Reset mid-frame: out_valid drops immediately. The partial frame is discarded and not counted.

Optional Feature:
- Macro: PACK_STR_SER_PARITY_EN.
- Defined: extra output out_par (1 bit) = even parity ^{out_data.a, out_data.b, out_idx}. It is valid with out_valid, 0 in reset, and held stable under backpressure.
- Undefined: port out_par and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset check: assert rst mid-SEND (frame 3'b111, after 1 beat) -> out_valid 0 and frm_ready 0 immediately. After release: frm_cnt 0, frm_ready 1, no residual beats.
- Full frame: mask 3'b111, elements 0/1/2 = 2'b01/2'b10/2'b11, out_ready=1 -> beats idx 0,1,2 with data 01,10,11 on 3 consecutive cycles. out_last only on idx 2; frm_cnt 0->1.
- Sparse mask: mask 3'b101 -> 2 beats, idx 0 then idx 2, with out_last on idx 2; element 1 never appears.
- Backpressure: out_ready=0 for 4 cycles while idx 1 is presented -> out_valid, out_idx=1 and out_data held constant. Beat completes on the first cycle out_ready=1.
- Back-to-back: second frame (mask 3'b111) offered during the last beat of the first -> accepted that cycle. 6 beats in 6 consecutive cycles; frm_cnt +2.
- Zero mask / wrap: frame with mask 3'b000 -> drop_pulse for 1 cycle, no beat, frm_cnt unchanged. Separately, 256 frames with CNT_W=8 -> frm_cnt wraps 255->0.
